// File: rtl/ab_pulse_gen.sv
// Command-driven two-line pulse generator for the A/B difference tracker,
// with a cycle-accurate mirror of the tracker's EQ/A_/B_ flags.
module ab_pulse_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_a_cnt,
  input  logic [CNT_W-1:0] cmd_b_cnt,
  output logic             outA,
  output logic             outB,
  output logic             busy,
  output logic             done,
  output logic             exp_AeqB,
  output logic             exp_AmB,
  output logic             exp_BmA
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {M_EQ, M_A, M_B} mirror_t;

  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t           r_state, w_state_nxt;
  mirror_t          r_mirror, w_mirror_nxt;
  logic [CNT_W-1:0] r_remA, r_remB;
  logic [CNT_W-1:0] w_remA_dec, w_remB_dec;
  logic [3:0]       r_gap_cnt;
  logic             w_accept;
  logic             w_zero_cmd;
  logic             w_last;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_zero_cmd = (cmd_a_cnt == '0) && (cmd_b_cnt == '0);
  // Counts saturate at zero so the shorter line simply stops pulsing.
  assign w_remA_dec = (r_remA != '0) ? r_remA - CNT_W'(1) : r_remA;
  assign w_remB_dec = (r_remB != '0) ? r_remB - CNT_W'(1) : r_remB;
  assign w_last     = (w_remA_dec == '0) && (w_remB_dec == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_zero_cmd ? S_DONE : S_PULSE;
      S_PULSE: begin
        if (w_last)        w_state_nxt = S_DONE;
        else if (GAP == 0) w_state_nxt = S_PULSE;
        else               w_state_nxt = S_GAP;
      end
      S_GAP:   if (r_gap_cnt == '0) w_state_nxt = S_PULSE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_remA    <= '0;
      r_remB    <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_remA <= cmd_a_cnt;
        r_remB <= cmd_b_cnt;
      end else if (r_state == S_PULSE) begin
        r_remA <= w_remA_dec;
        r_remB <= w_remB_dec;
      end
      if (r_state == S_PULSE)
        r_gap_cnt <= GAP_LAST;
      else if (r_state == S_GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - 4'd1;
    end
  end

  assign outA      = (r_state == S_PULSE) && (r_remA != '0);
  assign outB      = (r_state == S_PULSE) && (r_remB != '0);
  assign busy      = (r_state == S_PULSE) || (r_state == S_GAP);
  assign done      = (r_state == S_DONE);
  assign cmd_ready = (r_state == S_IDLE);

  // Mirror of the tracker: single-line pulses move one step toward that line.
  always_comb begin
    w_mirror_nxt = r_mirror;
    case (r_mirror)
      M_EQ: begin
        if (outA && !outB)      w_mirror_nxt = M_A;
        else if (!outA && outB) w_mirror_nxt = M_B;
      end
      M_A:     if (!outA && outB) w_mirror_nxt = M_EQ;
      M_B:     if (outA && !outB) w_mirror_nxt = M_EQ;
      default: w_mirror_nxt = M_EQ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_mirror <= M_EQ;
    else        r_mirror <= w_mirror_nxt;
  end

  assign exp_AeqB = (r_mirror == M_EQ);
  assign exp_AmB  = (r_mirror == M_A);
  assign exp_BmA  = (r_mirror == M_B);

endmodule

// File: tb/tb_ab_pulse_gen.sv
// Scoreboard bench for ab_pulse_gen: two instances (GAP=1 and GAP=0) checked
// cycle by cycle against a trace model built from the pulse-pattern rules.
module tb_ab_pulse_gen;

  typedef struct packed {
    logic       oa;
    logic       ob;
    logic       bz;
    logic       dn;
    logic [2:0] fl;
  } exp_t;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       r0, oa0, ob0, bz0, dn0, eq0, am0, bm0;
  logic       r1, oa1, ob1, bz1, dn1, eq1, am1, bm1;

  exp_t q0[$];
  exp_t q1[$];
  int   mdiff[2];
  int   total = 0;
  int   bad = 0;

  ab_pulse_gen #(.CNT_W(8), .GAP(1)) u_dut0 (
    .CLK(CLK), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(r0),
    .cmd_a_cnt(a0), .cmd_b_cnt(b0), .outA(oa0), .outB(ob0),
    .busy(bz0), .done(dn0), .exp_AeqB(eq0), .exp_AmB(am0), .exp_BmA(bm0)
  );

  ab_pulse_gen #(.CNT_W(8), .GAP(0)) u_dut1 (
    .CLK(CLK), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(r1),
    .cmd_a_cnt(a1), .cmd_b_cnt(b1), .outA(oa1), .outB(ob1),
    .busy(bz1), .done(dn1), .exp_AeqB(eq1), .exp_AmB(am1), .exp_BmA(bm1)
  );

  function automatic logic [2:0] flags_of(input int diff);
    if (diff > 0)      return 3'b010;
    else if (diff < 0) return 3'b001;
    else               return 3'b100;
  endfunction

  task automatic cmp(input string nm, input int d, input logic [7:0] act,
                     input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, req);
    end
  endtask

  // Expected per-cycle trace for one command; the mirror is a difference
  // count saturating at +/-1.
  task automatic build(input int a, input int b, input int gap,
                       inout int diff, output exp_t tr[$]);
    int   p;
    logic pa, pb;
    tr = {};
    p = (a > b) ? a : b;
    for (int i = 0; i < p; i++) begin
      pa = (i < a);
      pb = (i < b);
      tr.push_back('{pa, pb, 1'b1, 1'b0, flags_of(diff)});
      if (pa && !pb) diff = (diff < 1) ? diff + 1 : diff;
      if (pb && !pa) diff = (diff > -1) ? diff - 1 : diff;
      if (i != p - 1)
        for (int g = 0; g < gap; g++)
          tr.push_back('{1'b0, 1'b0, 1'b1, 1'b0, flags_of(diff)});
    end
    tr.push_back('{1'b0, 1'b0, 1'b0, 1'b1, flags_of(diff)});
  endtask

  // Called at posedge+1; holds cmd_valid until the DUT is ready, then the
  // following edge accepts the command.
  task automatic issue(input int d, input int a, input int b);
    exp_t tr[$];
    int   cyc;
    cyc = 0;
    if (d == 0) begin a0 = 8'(a); b0 = 8'(b); v0 = 1'b1; end
    else        begin a1 = 8'(a); b1 = 8'(b); v1 = 1'b1; end
    while (((d == 0) ? r0 : r1) !== 1'b1 && cyc < 3000) begin
      @(posedge CLK); #1;
      cyc++;
    end
    if (cyc >= 3000) begin
      cmp("accept_timeout", d, 8'(cyc), 8'd0);
      if (d == 0) v0 = 1'b0; else v1 = 1'b0;
      return;
    end
    build(a, b, (d == 0) ? 1 : 0, mdiff[d], tr);
    foreach (tr[i]) begin
      if (d == 0) q0.push_back(tr[i]);
      else        q1.push_back(tr[i]);
    end
    @(posedge CLK); #1;
    if (d == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic chk(input int d, input logic oa, input logic ob, input logic bz,
                     input logic dn, input logic rdy, input logic [2:0] fl);
    exp_t e;
    int   n;
    n = (d == 0) ? q0.size() : q1.size();
    if (bz || dn) begin
      if (n == 0) begin
        cmp("unexpected_activity", d, {6'b0, bz, dn}, 8'h00);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        cmp("cycle_outputs", d, {1'b0, oa, ob, bz, dn, fl}, {1'b0, e});
        cmp("ready_while_active", d, {7'b0, rdy}, 8'h00);
      end
    end else if (n == 0) begin
      cmp("idle_outputs", d, {2'b0, oa, ob, rdy, fl},
          {2'b0, 1'b0, 1'b0, 1'b1, flags_of(mdiff[d])});
    end
  endtask

  always @(negedge CLK) begin
    if (rst_n) begin
      chk(0, oa0, ob0, bz0, dn0, r0, {eq0, am0, bm0});
      chk(1, oa1, ob1, bz1, dn1, r1, {eq1, am1, bm1});
    end
  end

  initial begin
    int cyc;
    mdiff[0] = 0;
    mdiff[1] = 0;
    #2;
    cmp("reset_values", 0, {1'b0, oa0, ob0, bz0, dn0, r0, eq0, am0}, 8'b0000_0110);
    cmp("reset_values", 1, {1'b0, oa1, ob1, bz1, dn1, r1, eq1, bm1}, 8'b0000_0110);
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK); #1;

    issue(0, 3, 0);            // A only, GAP=1
    issue(1, 2, 2);            // equal counts, GAP=0
    issue(0, 1, 3);            // mixed counts
    issue(0, 0, 0);            // zero commands
    issue(1, 0, 0);
    issue(0, 2, 0);            // back-to-back with cmd_valid held
    issue(0, 0, 1);
    issue(1, 1, 4);
    issue(1, 3, 0);

    // Reset in the middle of a burst.
    issue(0, 5, 0);
    repeat (4) @(posedge CLK);
    #3 rst_n = 1'b0;
    #1;
    cmp("midreset_outputs", 0, {1'b0, oa0, bz0, dn0, r0, eq0, am0, bm0}, 8'b0000_1100);
    q0.delete();
    q1.delete();
    mdiff[0] = 0;
    mdiff[1] = 0;
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK); #1;
    issue(0, 1, 0);

    // Full-scale counts.
    issue(0, 255, 0);
    issue(1, 0, 255);
    issue(0, 0, 255);

    for (int i = 0; i < 40; i++) begin
      int d, a, b;
      d = int'($urandom_range(0, 1));
      a = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 255));
      issue(d, a, b);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end

    cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0 || !r0 || !r1) && cyc < 5000) begin
      @(posedge CLK); #1;
      cyc++;
    end
    if (cyc >= 5000) cmp("drain_timeout", 0, 8'(q0.size() + q1.size()), 8'd0);
    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ab_pulse_gen.md
# ab_pulse_gen

Command-driven generator of the two-line pulse stream that the A/B difference tracker consumes. It takes a command of "emit N pulses on A and M pulses on B" and drives `outA`/`outB` on the tracker's `inA`/`inB`, on the same clock. It also keeps a cycle-accurate mirror of the tracker's EQ/A_/B_ state on `exp_*` outputs, so benches and higher-level sequencers can check the tracker's flags without a separate reference model.

## Interface
- `CNT_W`, default 8: width of the per-line pulse counts.
- `GAP`, default 1: idle cycles inserted between consecutive pulse cycles. Legal range is 0..15.
- `CLK` in 1: clock. All logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low. Clock `CLK`.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: generator can accept a command. High only in IDLE.
- `cmd_a_cnt` in CNT_W: number of pulses to emit on `outA`.
- `cmd_b_cnt` in CNT_W: number of pulses to emit on `outB`.
- `outA` out 1: pulse line A, connected to the tracker's `inA`.
- `outB` out 1: pulse line B, connected to the tracker's `inB`.
- `busy` out 1: a command is in progress (PULSE or GAP state).
- `done` out 1: single-cycle strobe when a command completes.
- `exp_AeqB`, `exp_AmB`, `exp_BmA` out 1 each: predicted tracker flags. Exactly one is high at any time.

## Operation
- **Handshake:** a command is accepted on the rising edge where `cmd_valid & cmd_ready`. On that edge `cmd_a_cnt` and `cmd_b_cnt` are latched into `remA` and `remB`. Command inputs are ignored at all other times.
- **FSM states:** IDLE, PULSE, GAP, DONE. Reset state is IDLE.
- **IDLE:**
  - On accept with both counts zero: go to DONE.
  - On any other accept: go to PULSE.
- **PULSE (one cycle):**
  - Drive `outA = (remA != 0)` and `outB = (remB != 0)`.
  - Decrement each nonzero remaining count.
  - If both counts are zero after the decrement: go to DONE.
  - Otherwise: go to PULSE if `GAP == 0`, else go to GAP.
- **GAP:** `outA = outB = 0`. A gap counter runs for exactly `GAP` cycles, then the FSM goes to PULSE.
- **DONE (one cycle):** `done = 1`, then go to IDLE.
- **Pulse pattern:** while both lines have pulses remaining, they pulse in the same cycle. The surplus line then pulses alone. Total pulse cycles P = max(a, b).
- **Output decode:** `outA`, `outB`, `busy`, `done` and `cmd_ready` are decoded combinationally from registered state and counters only. No combinational path runs from command inputs to outputs.
- **Mirror FSM** (EQ, A_, B_; reset EQ), updated on every edge using the current `outA`/`outB`:
  - EQ goes to A_ on `outA & ~outB`, and to B_ on `~outA & outB`.
  - A_ goes to EQ on `~outA & outB`.
  - B_ goes to EQ on `outA & ~outB`.
  - All other cases hold the state. This includes both lines high and both lines low.
- **Mirror flags:** `exp_AeqB` is high in EQ, `exp_AmB` in A_, `exp_BmA` in B_.
- **Mirror persistence:** the mirror is not cleared between commands. It tracks the tracker for as long as both are out of reset.

## Timing
- **Reset values:** `outA = 0`, `outB = 0`, `busy = 0`, `done = 0`, `cmd_ready = 1`, `exp_AeqB = 1`, `exp_AmB = 0`, `exp_BmA = 0`.
- **Reset mid-operation:** the FSM returns to IDLE and the mirror to EQ asynchronously. Counters are cleared and the in-flight command is discarded. The first accept is possible on the first rising edge with `rst_n` high.
- **Latency, command accepted at edge k:**
  - The first PULSE cycle is the cycle after edge k.
  - `done` is high in cycle k + 1 + P + (P − 1)·GAP.
  - `cmd_ready` returns high in the following cycle.
  - The earliest next accept is the edge that ends that cycle.
- **Zero command** (a = b = 0): no pulses are emitted, and `done` is high in the cycle after edge k.
- **Mirror timing:** `exp_*` change on the edge that ends a pulse cycle. This is the same edge on which the tracker samples, so `exp_*` equals the tracker's outputs every cycle when both share `CLK` and `rst_n`.
- **Count width:** counts are unsigned. The maximum is 2^CNT_W − 1 pulses per line, with no wrap: a count decrements to 0 and stops.

## Test plan
1. **A-only command.** After reset, send a = 3, b = 0 with GAP = 1, accepted at edge k.
   - `outA` is high in cycles k+1, k+3, k+5; `outB` stays 0.
   - `exp_AmB` is high from cycle k+2 onward.
   - `done` is high in cycle k+6.
2. **Equal counts.** Send a = 2, b = 2 with GAP = 0.
   - `outA` and `outB` are both high in cycles k+1 and k+2.
   - `exp_AeqB` stays 1 throughout.
   - `done` is high in cycle k+3.
3. **Mixed counts.** Send a = 1, b = 3 with GAP = 1.
   - Cycle k+1: both lines high.
   - Cycles k+3 and k+5: `outB` only.
   - The mirror is EQ until the end of cycle k+3, then B_ and stays B_.
   - `done` is high in cycle k+6.
4. **Zero command.** Send a = 0, b = 0.
   - No pulses are emitted.
   - `done` is high in cycle k+1.
   - `cmd_ready` is high again in cycle k+2.
5. **Back-to-back commands.** Hold `cmd_valid` high with a second command (a = 0, b = 1) queued behind a = 2, b = 0.
   - `cmd_ready` is 0 while the first command runs, so the second command is not taken early.
   - The second command is accepted at the edge ending the cycle after `done`.
   - The mirror moves A_ → EQ on its B pulse.
6. **Reset mid-operation.** Assert `rst_n = 0` in the middle of an a = 5, b = 0 burst.
   - `outA`, `busy` and `done` drop to 0 immediately.
   - `exp_AeqB` goes to 1 and `cmd_ready` goes to 1.
   - After release, the command a = 1, b = 0 gives exactly one `outA` pulse.
